vram_scan_scheduler: RTL and testbench
======================================

Name: vram_scan_scheduler

Overview:
- Sequences display-side reads of the 160x144 GBC frame buffer for the 1280x720 VGA output.
- Owns the raster counters and sync generation.
- Produces integer-scaled, centred VRAM read addresses without multipliers.
- Runs a triple-buffer bank scheduler: the capture path always writes a bank that is not displayed, and display bank swaps happen only at vertical sync start.

Parameters:
- H_FP, 110, horizontal front porch (pixels)
- H_SW, 40, horizontal sync width
- H_BP, 220, horizontal back porch
- H_ACT, 1280, active pixels per line
- V_ACT, 720, active lines
- V_FP, 5, vertical front porch (lines)
- V_SW, 5, vertical sync width
- V_BP, 20, vertical back porch
- SRC_W, 160, source frame width
- SRC_H, 144, source frame height
- SCALE, 4, integer pixel/line replication factor
- X_OFF, 320, window start, pixels after active start
- Y_OFF, 72, window start line
- ADDR_WIDTH, 15, in-bank VRAM address width

Ports:
- clk_pixel  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- cap_frame_done  in  1  one-cycle pulse, already synchronised to clk_pixel: capture finished writing cap_bank
- cap_bank  out  2  bank the capture path must write (0..2)
- rd_bank  out  2  bank being displayed
- rd_addr  out  ADDR_WIDTH  in-bank read address to VRAM (1-cycle registered read)
- pix_de  out  1  window enable aligned with VRAM read data
- hsync  out  1  active-high, aligned with pix_de
- vsync  out  1  active-high, aligned with pix_de
- frame_start  out  1  one-cycle pulse when h=0, v=0 (counter stage)
- drop_count  out  8  completed capture frames overwritten before display; saturates at 255

Behaviour:
- Counters: h 0..LINE-1 (LINE=1650); v 0..SCREEN-1 (SCREEN=750).
  - h wraps at LINE-1 and increments v; v wraps at SCREEN-1 at the same edge.
- Counter-stage timing:
  - hsync_c = h in [H_FP, H_FP+H_SW)
  - vsync_c = v in [V_ACT+V_FP, V_ACT+V_FP+V_SW)
  - active start HA = H_FP+H_SW+H_BP = 370
- Window (counter stage): h in [HA+X_OFF, HA+X_OFF+SRC_W*SCALE) and v in [Y_OFF, Y_OFF+SRC_H*SCALE), i.e. h 690..1329, v 72..647.
- Address generation, no multipliers:
  - sx/sy: sub-counters 0..SCALE-1.
  - src_x increments when sx wraps; it resets to 0 at the window's left edge.
  - row_base adds SRC_W when sy wraps at end of a window line; it resets to 0 at v=0.
  - rd_addr = row_base + src_x, registered one cycle after the counter stage.
  - Outside the window, rd_addr holds 0.
- Pipeline:
  - hsync, vsync and pix_de are delayed 2 cycles from the counter stage, so they align with VRAM o_dataOut.
  - frame_start is not delayed.
- Bank scheduler (triple buffer):
  - State is disp (D), cap (C), ready (R) and ready_valid.
  - Reset values: D=0, C=1, R=2, ready_valid=0.
  - On cap_frame_done with ready_valid=0: R<=C, C<=old R (the free bank), ready_valid<=1.
  - On cap_frame_done with ready_valid=1: R<=C, C<=old R (stale ready frame discarded), drop_count++ (saturating).
  - Swap point is the counter stage at h=0, v=V_ACT+V_FP (first vsync line).
  - At the swap point with ready_valid=1: D<=R, R<=old D, ready_valid<=0.
  - At the swap point with ready_valid=0: no change.
  - If cap_frame_done coincides with the swap point, apply the swap first, then the done rule to the post-swap state, in the same cycle. Result: D=old R, R=old C, C=old D, ready_valid=1, no drop.
  - Invariant: D, C and R are always pairwise distinct.
  - rd_bank = D and cap_bank = C, both registered.
- Reset, including mid-frame:
  - h=v=0, all pipeline stages 0, hsync=vsync=pix_de=0, rd_addr=0, frame_start=0, drop_count=0, banks as above.
  - After release, the first frame_start occurs on the first clock edge.

Test Plan:
- Reset release, run 1 line -> hsync high for exactly 40 cycles, rising 112 cycles after the h=0 counter edge (110 + 2-cycle pipeline); line period 1650.
- Run full frame -> vsync high for 5 lines (v 725..729), period 750 lines; pix_de high 640 cycles/line on 576 lines, 0 elsewhere.
- Window addresses -> at v=72, the first 4 addresses are 0, the next 4 are 1; last on the line is 159. v=76 starts at 160; v=647 ends at 23039 (=SRC_W*SRC_H-1).
- One cap_frame_done mid-frame -> cap_bank 1->2 immediately. At next v=725, h=0: rd_bank 0->1, drop_count 0.
- Two cap_frame_done before vsync -> second pulse gives drop_count=1, cap_bank returns to 1; swap shows bank 2; rd_bank is never equal to cap_bank.
- cap_frame_done on the swap cycle with ready_valid=1, and reset_n low mid-line -> first case: D=old R, ready_valid=1, no drop. Second case: all outputs go to reset values immediately (asynchronously).

Source files
------------

// File: rtl/vram_scan_scheduler_if.sv
// Display-side bundle of the VRAM scan scheduler: capture handshake, bank
// selects, VRAM read address and the pixel-aligned timing outputs.
interface vram_scan_scheduler_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  cap_frame_done;
  logic [1:0]            cap_bank;
  logic [1:0]            rd_bank;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  pix_de;
  logic                  hsync;
  logic                  vsync;
  logic                  frame_start;
  logic [7:0]            drop_count;

  modport master (
    input  cap_frame_done,
    output cap_bank, rd_bank, rd_addr, pix_de, hsync, vsync, frame_start, drop_count
  );

  modport slave (
    output cap_frame_done,
    input  cap_bank, rd_bank, rd_addr, pix_de, hsync, vsync, frame_start, drop_count
  );
endinterface

// File: rtl/vram_scan_scheduler.sv
// Raster timing, multiplier-free integer-scaled VRAM addressing and a
// triple-buffer bank scheduler for showing the GBC frame on 720p output.
module vram_scan_scheduler #(
  parameter int H_FP       = 110,
  parameter int H_SW       = 40,
  parameter int H_BP       = 220,
  parameter int H_ACT      = 1280,
  parameter int V_ACT      = 720,
  parameter int V_FP       = 5,
  parameter int V_SW       = 5,
  parameter int V_BP       = 20,
  parameter int SRC_W      = 160,
  parameter int SRC_H      = 144,
  parameter int SCALE      = 4,
  parameter int X_OFF      = 320,
  parameter int Y_OFF      = 72,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                   clk_pixel,
  input  logic                   reset_n,
  vram_scan_scheduler_if.master  bus
);

  localparam int LINE   = H_FP + H_SW + H_BP + H_ACT;
  localparam int SCREEN = V_ACT + V_FP + V_SW + V_BP;
  localparam int HA     = H_FP + H_SW + H_BP;
  localparam int H_W    = $clog2(LINE);
  localparam int V_W    = $clog2(SCREEN);
  localparam int SX_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int SRCX_W = $clog2(SRC_W + 1);
  localparam int PIPE   = 2;

  localparam logic [H_W-1:0] H_LAST     = H_W'(LINE - 1);
  localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_FP);
  localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_FP + H_SW);
  localparam logic [H_W-1:0] WIN_X0     = H_W'(HA + X_OFF);
  localparam logic [H_W-1:0] WIN_X1     = H_W'(HA + X_OFF + SRC_W * SCALE);
  localparam logic [H_W-1:0] WIN_X_LAST = H_W'(HA + X_OFF + SRC_W * SCALE - 1);
  localparam logic [V_W-1:0] V_LAST     = V_W'(SCREEN - 1);
  localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACT + V_FP);
  localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACT + V_FP + V_SW);
  localparam logic [V_W-1:0] WIN_Y0     = V_W'(Y_OFF);
  localparam logic [V_W-1:0] WIN_Y1     = V_W'(Y_OFF + SRC_H * SCALE);
  localparam logic [SX_W-1:0]       SUB_LAST = SX_W'(SCALE - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(SRC_W);

  logic [H_W-1:0]        h_reg;
  logic [V_W-1:0]        v_reg;
  logic [SX_W-1:0]       sx_reg;
  logic [SX_W-1:0]       sy_reg;
  logic [SRCX_W-1:0]     src_x_reg;
  logic [ADDR_WIDTH-1:0] row_base_reg;
  logic [ADDR_WIDTH-1:0] rd_addr_reg;
  logic [PIPE-1:0][2:0]  pipe_reg;
  logic                  frame_start_reg;

  logic [1:0] d_reg, c_reg, r_reg;
  logic [1:0] d_next, c_next, r_next, free_bank;
  logic       rv_reg, rv_next;
  logic [7:0] drop_reg, drop_next;

  logic h_end, v_end, hs_c, vs_c, win_h, win_v, win_c, swap_pt;

  assign h_end   = (h_reg == H_LAST);
  assign v_end   = (v_reg == V_LAST);
  assign hs_c    = (h_reg >= H_SYNC_BEG) && (h_reg < H_SYNC_END);
  assign vs_c    = (v_reg >= V_SYNC_BEG) && (v_reg < V_SYNC_END);
  assign win_h   = (h_reg >= WIN_X0) && (h_reg < WIN_X1);
  assign win_v   = (v_reg >= WIN_Y0) && (v_reg < WIN_Y1);
  assign win_c   = win_h && win_v;
  assign swap_pt = (h_reg == '0) && (v_reg == V_SYNC_BEG);

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (h_end) begin
      h_reg <= '0;
      v_reg <= v_end ? '0 : v_reg + V_W'(1);
    end else begin
      h_reg <= h_reg + H_W'(1);
    end
  end

  // Scaling by replication: sub-counters step the source coordinates every
  // SCALE pixels/lines, so the address is built from adds alone.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      sx_reg       <= '0;
      src_x_reg    <= '0;
      sy_reg       <= '0;
      row_base_reg <= '0;
    end else begin
      if (win_h) begin
        if (sx_reg == SUB_LAST) begin
          sx_reg    <= '0;
          src_x_reg <= src_x_reg + SRCX_W'(1);
        end else begin
          sx_reg <= sx_reg + SX_W'(1);
        end
      end else begin
        sx_reg    <= '0;
        src_x_reg <= '0;
      end

      if (h_end && v_end) begin
        sy_reg       <= '0;
        row_base_reg <= '0;
      end else if (win_v && (h_reg == WIN_X_LAST)) begin
        if (sy_reg == SUB_LAST) begin
          sy_reg       <= '0;
          row_base_reg <= row_base_reg + ROW_STEP;
        end else begin
          sy_reg <= sy_reg + SX_W'(1);
        end
      end
    end
  end

  // Address leaves one cycle after the counters; the sync/enable path is two
  // deep so it lines up with the registered VRAM read data.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_reg     <= '0;
      pipe_reg        <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      rd_addr_reg     <= win_c ? (row_base_reg + ADDR_WIDTH'(src_x_reg)) : '0;
      pipe_reg        <= {pipe_reg[PIPE-2:0], {hs_c, vs_c, win_c}};
      frame_start_reg <= (h_reg == '0) && (v_reg == '0);
    end
  end

  // Swap is resolved before a coincident capture completion, so the freshly
  // finished frame becomes the new ready bank without counting as a drop.
  always_comb begin
    d_next    = d_reg;
    c_next    = c_reg;
    r_next    = r_reg;
    rv_next   = rv_reg;
    drop_next = drop_reg;
    free_bank = r_reg;
    if (swap_pt && rv_reg) begin
      d_next  = r_reg;
      r_next  = d_reg;
      rv_next = 1'b0;
    end
    if (bus.cap_frame_done) begin
      if (rv_next && (drop_reg != 8'hFF)) begin
        drop_next = drop_reg + 8'd1;
      end
      free_bank = r_next;
      r_next    = c_next;
      c_next    = free_bank;
      rv_next   = 1'b1;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      d_reg    <= 2'd0;
      c_reg    <= 2'd1;
      r_reg    <= 2'd2;
      rv_reg   <= 1'b0;
      drop_reg <= 8'd0;
    end else begin
      d_reg    <= d_next;
      c_reg    <= c_next;
      r_reg    <= r_next;
      rv_reg   <= rv_next;
      drop_reg <= drop_next;
    end
  end

  assign bus.rd_addr     = rd_addr_reg;
  assign bus.hsync       = pipe_reg[PIPE-1][2];
  assign bus.vsync       = pipe_reg[PIPE-1][1];
  assign bus.pix_de      = pipe_reg[PIPE-1][0];
  assign bus.frame_start = frame_start_reg;
  assign bus.rd_bank     = d_reg;
  assign bus.cap_bank    = c_reg;
  assign bus.drop_count  = drop_reg;

endmodule

// File: tb/tb_vram_scan_scheduler.sv
// Directed bench for vram_scan_scheduler on a shrunken raster (36x19 clocks,
// 4x3 source, x2 scaling) so whole frames and bank swaps run quickly.
module tb_vram_scan_scheduler;

  localparam int T_H_FP = 4, T_H_SW = 3, T_H_BP = 5, T_H_ACT = 24;
  localparam int T_V_ACT = 12, T_V_FP = 2, T_V_SW = 2, T_V_BP = 3;
  localparam int T_SRC_W = 4, T_SRC_H = 3, T_SCALE = 2;
  localparam int T_X_OFF = 6, T_Y_OFF = 3, AW = 15;

  // Hand-derived: LINE=4+3+5+24=36, SCREEN=12+2+2+3=19, HA=12, window h 18..25, v 3..8.
  localparam int LINE  = 36;
  localparam int SCREEN = 19;
  localparam int FRAME = LINE * SCREEN;
  localparam int WX0   = 18;
  localparam int WX1   = 26;
  localparam int WY0   = 3;
  localparam int WY1   = 9;
  localparam int SWAP  = 14 * LINE;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pos;

  always #5 clk_pixel = ~clk_pixel;

  vram_scan_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

  vram_scan_scheduler #(
    .H_FP(T_H_FP), .H_SW(T_H_SW), .H_BP(T_H_BP), .H_ACT(T_H_ACT),
    .V_ACT(T_V_ACT), .V_FP(T_V_FP), .V_SW(T_V_SW), .V_BP(T_V_BP),
    .SRC_W(T_SRC_W), .SRC_H(T_SRC_H), .SCALE(T_SCALE),
    .X_OFF(T_X_OFF), .Y_OFF(T_Y_OFF), .ADDR_WIDTH(AW)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  // Raster position (v*LINE+h) of the counter stage after the latest edge.
  always @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) pos <= 0;
    else          pos <= (pos + 1) % FRAME;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(int i);
    int h = i % LINE;
    int v = (i / LINE) % SCREEN;
    return (h >= WX0) && (h < WX1) && (v >= WY0) && (v < WY1);
  endfunction

  function automatic int addr_of(int i);
    int h = i % LINE;
    int v = (i / LINE) % SCREEN;
    return ((v - WY0) / T_SCALE) * T_SRC_W + (h - WX0) / T_SCALE;
  endfunction

  // Expected {frame_start, hsync, vsync, pix_de, rd_addr} after edge k since release.
  function automatic logic [18:0] exp_vec(int k);
    logic fs, hs, vs, de;
    logic [14:0] a;
    int h2, v2;
    fs = (k >= 1) && (((k - 1) % FRAME) == 0);
    h2 = (k - 2) % LINE;
    v2 = ((k - 2) / LINE) % SCREEN;
    hs = (k >= 2) && (h2 >= 4) && (h2 < 7);
    vs = (k >= 2) && (v2 >= 14) && (v2 < 16);
    de = (k >= 2) && in_win(k - 2);
    a  = ((k >= 1) && in_win(k - 1)) ? 15'(addr_of(k - 1)) : 15'd0;
    return {fs, hs, vs, de, a};
  endfunction

  task automatic wait_pos(input int target);
    bit found = 1'b0;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      @(negedge clk_pixel);
      check("distinct", 32'(bus.rd_bank != bus.cap_bank), 32'd1);
      if (pos == target) found = 1'b1;
    end
    check("reach_pos", 32'(found), 32'd1);
  endtask

  task automatic pulse_done();
    bus.cap_frame_done = 1'b1;
    @(negedge clk_pixel);
    bus.cap_frame_done = 1'b0;
  endtask

  task automatic check_reset(input string p);
    check({p, "_hsync"},  32'(bus.hsync), 32'd0);
    check({p, "_vsync"},  32'(bus.vsync), 32'd0);
    check({p, "_de"},     32'(bus.pix_de), 32'd0);
    check({p, "_fs"},     32'(bus.frame_start), 32'd0);
    check({p, "_addr"},   32'(bus.rd_addr), 32'd0);
    check({p, "_rdbank"}, 32'(bus.rd_bank), 32'd0);
    check({p, "_capbank"},32'(bus.cap_bank), 32'd1);
    check({p, "_drop"},   32'(bus.drop_count), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs_cnt = 0, vs_cnt = 0, de_cnt = 0, addr_max = 0;
    bus.cap_frame_done = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_pixel);
    check_reset("rst");

    reset_n = 1'b1;
    for (int k = 1; k <= FRAME + LINE + 4; k++) begin
      @(negedge clk_pixel);
      check($sformatf("scan@%0d", k),
            32'({bus.frame_start, bus.hsync, bus.vsync, bus.pix_de, bus.rd_addr}),
            32'(exp_vec(k)));
      if (k >= 2 && k <= FRAME + 1) begin
        hs_cnt += int'(bus.hsync);
        vs_cnt += int'(bus.vsync);
        de_cnt += int'(bus.pix_de);
        if (int'(bus.rd_addr) > addr_max) addr_max = int'(bus.rd_addr);
      end
    end
    check("hsync_per_frame", 32'(hs_cnt), 32'd57);   // 3 cycles x 19 lines
    check("vsync_per_frame", 32'(vs_cnt), 32'd72);   // 2 lines x 36 cycles
    check("de_per_frame",    32'(de_cnt), 32'd48);   // 8 pixels x 6 lines
    check("addr_last",       32'(addr_max), 32'd11); // SRC_W*SRC_H-1

    // One completion mid-frame, shown at the next swap point.
    wait_pos(5 * LINE + 10);
    pulse_done();
    check("a_cap", 32'(bus.cap_bank), 32'd2);
    check("a_rd",  32'(bus.rd_bank), 32'd0);
    wait_pos(SWAP);
    check("a_rd_preswap", 32'(bus.rd_bank), 32'd0);
    @(negedge clk_pixel);
    check("a_rd_swap",  32'(bus.rd_bank), 32'd1);
    check("a_cap_swap", 32'(bus.cap_bank), 32'd2);
    check("a_drop",     32'(bus.drop_count), 32'd0);

    // Two completions before vsync: the older ready frame is dropped.
    wait_pos(2 * LINE + 5);
    pulse_done();
    check("b_cap1", 32'(bus.cap_bank), 32'd0);
    check("b_drop1", 32'(bus.drop_count), 32'd0);
    wait_pos(4 * LINE + 5);
    pulse_done();
    check("b_cap2", 32'(bus.cap_bank), 32'd2);
    check("b_drop2", 32'(bus.drop_count), 32'd1);
    wait_pos(SWAP);
    @(negedge clk_pixel);
    check("b_rd_swap",  32'(bus.rd_bank), 32'd0);
    check("b_cap_swap", 32'(bus.cap_bank), 32'd2);

    // Completion landing exactly on the swap cycle.
    wait_pos(5 * LINE + 10);
    pulse_done();
    check("c_cap1", 32'(bus.cap_bank), 32'd1);
    wait_pos(SWAP);
    pulse_done();
    check("c_rd",   32'(bus.rd_bank), 32'd2);
    check("c_cap",  32'(bus.cap_bank), 32'd0);
    check("c_drop", 32'(bus.drop_count), 32'd1);
    wait_pos(SWAP);
    @(negedge clk_pixel);
    check("c_rd_next",  32'(bus.rd_bank), 32'd1);
    check("c_cap_next", 32'(bus.cap_bank), 32'd0);
    check("c_drop_next", 32'(bus.drop_count), 32'd1);

    // Back-to-back completions saturate the drop counter.
    wait_pos(LINE + 1);
    bus.cap_frame_done = 1'b1;
    repeat (300) @(negedge clk_pixel);
    bus.cap_frame_done = 1'b0;
    check("d_drop_sat", 32'(bus.drop_count), 32'd255);
    check("d_rd",       32'(bus.rd_bank), 32'd1);
    check("d_distinct", 32'(bus.rd_bank != bus.cap_bank), 32'd1);

    // Asynchronous reset in the middle of a window line.
    wait_pos(6 * LINE + 22);
    check("e_de_pre",   32'(bus.pix_de), 32'd1);
    check("e_addr_pre", 32'(bus.rd_addr), 32'd5);
    #2 reset_n = 1'b0;
    #1 check_reset("arst");
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    @(negedge clk_pixel);
    check("e_fs_first",  32'(bus.frame_start), 32'd1);
    check("e_addr_first", 32'(bus.rd_addr), 32'd0);
    check("e_rd_first",  32'(bus.rd_bank), 32'd0);
    check("e_cap_first", 32'(bus.cap_bank), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
